border_painter_flash: RTL and testbench

- Parametrised next-generation border painter for the pong playfield.
- Paints the left and right goal borders, plus optional top and bottom walls, in a 6-bit BBGGRR colour.
- Adds per-side goal-flash animation that is sequenced per frame.
- Outputs are registered, one pixel clock after hpos/vpos; sits beside the paddle/ball painters, ahead of the colour mux.

---
 rtl/border_painter_flash.sv | 65 ++++++
 tb/tb_border_painter_flash.sv | 118 +++++++++++
 2 files changed

// File: rtl/border_painter_flash.sv
// border_painter_flash: pong goal borders with per-side goal-flash animation; optional walls via BORDER_TOP_BOTTOM_EN
module border_painter_flash #(
  parameter int         BORDER_WIDTH      = 8,
  parameter int         H_ACTIVE          = 640,
  parameter int         V_ACTIVE          = 480,
  parameter logic [5:0] BORDER_COLOR      = 6'b111111,
  parameter logic [5:0] FLASH_COLOR       = 6'b000011,
  parameter int         FLASH_FRAMES      = 32,
  parameter int         FLASH_HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       frame_start,
  input  logic       flash_left,
  input  logic       flash_right,
  output logic       in_border,
  output logic [5:0] color,
  output logic       flash_busy
);
  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam int HB = $clog2(FLASH_HALF_PERIOD);
  localparam logic [CW-1:0] FF = CW'(FLASH_FRAMES);
  logic [CW-1:0] cnt_left, cnt_right, el, er;
  logic [5:0] lc, rc;
  logic l, r, tb, act;
  // region decode and per-side phase colour; half period is a power of two so the phase is one bit of elapsed
  always_comb begin
    el = FF - cnt_left;
    er = FF - cnt_right;
    lc = (cnt_left != '0 && !el[HB]) ? FLASH_COLOR : BORDER_COLOR;
    rc = (cnt_right != '0 && !er[HB]) ? FLASH_COLOR : BORDER_COLOR;
    act = hpos < 10'(H_ACTIVE) && vpos < 9'(V_ACTIVE);
    l = hpos < 10'(BORDER_WIDTH);
    r = hpos >= 10'(H_ACTIVE - BORDER_WIDTH) && hpos < 10'(H_ACTIVE);
  end
`ifdef BORDER_TOP_BOTTOM_EN
  assign tb = vpos < 9'(BORDER_WIDTH) || (vpos >= 9'(V_ACTIVE - BORDER_WIDTH) && vpos < 9'(V_ACTIVE));
`else
  assign tb = 1'b0;
`endif
  // flash counters: trigger reloads and beats a same-cycle frame_start; count down once per frame, stop at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_left  <= '0;
      cnt_right <= '0;
    end else begin
      cnt_left  <= flash_left ? FF : (frame_start && cnt_left != '0) ? cnt_left - CW'(1) : cnt_left;
      cnt_right <= flash_right ? FF : (frame_start && cnt_right != '0) ? cnt_right - CW'(1) : cnt_right;
    end
  end
  // registered outputs; left beats right beats walls
  always_ff @(posedge clk) begin
    if (reset) begin
      in_border  <= 1'b0;
      color      <= 6'b000000;
      flash_busy <= 1'b0;
    end else begin
      in_border  <= act && (l || r || tb);
      color      <= !act ? 6'b000000 : l ? lc : r ? rc : tb ? BORDER_COLOR : 6'b000000;
      flash_busy <= cnt_left != '0 || cnt_right != '0;
    end
  end
endmodule

// File: tb/tb_border_painter_flash.sv
// tb_border_painter_flash: directed plus random checks of border_painter_flash against a frame-level model
module tb_border_painter_flash;
  localparam int BW = 8, HA = 640, VA = 480, BC = 63, FC = 3, FF = 32, HP = 4;
  logic clk = 0, reset = 0, frame_start = 0, flash_left = 0, flash_right = 0;
  logic [9:0] hpos = 0;
  logic [8:0] vpos = 0;
  logic in_border, flash_busy;
  logic [5:0] color;
  int n_cmp = 0, n_bad = 0, ml = 0, mr = 0;

  border_painter_flash dut (.clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .frame_start(frame_start), .flash_left(flash_left), .flash_right(flash_right),
    .in_border(in_border), .color(color), .flash_busy(flash_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ph(input int c);
    return (c != 0 && ((FF - c) / HP) % 2 == 0) ? FC : BC;
  endfunction

  task automatic cyc(input int h, input int v, input bit fs, input bit fl, input bit fr, input bit rs);
    int e_in, e_col, e_busy;
    bit act, l, r, tb;
    hpos = 10'(h); vpos = 9'(v);
    frame_start = fs; flash_left = fl; flash_right = fr; reset = rs;
    @(posedge clk);
    act = h < HA && v < VA;
    l = h < BW;
    r = h >= HA - BW && h < HA;
`ifdef BORDER_TOP_BOTTOM_EN
    tb = v < BW || (v >= VA - BW && v < VA);
`else
    tb = 0;
`endif
    e_in = (!rs && act && (l || r || tb)) ? 1 : 0;
    e_col = e_in == 0 ? 0 : l ? ph(ml) : r ? ph(mr) : BC;
    e_busy = (!rs && (ml != 0 || mr != 0)) ? 1 : 0;
    if (rs) begin ml = 0; mr = 0; end
    else begin
      ml = fl ? FF : (fs && ml > 0) ? ml - 1 : ml;
      mr = fr ? FF : (fs && mr > 0) ? mr - 1 : mr;
    end
    #1;
    chk("in_border", in_border, e_in);
    chk("color", color, e_col);
    chk("flash_busy", flash_busy, e_busy);
  endtask

  task automatic px(input int h, input int v);
    cyc(h, v, 0, 0, 0, 0);
  endtask

  task automatic frame();
    px(3, 100);
    px(636, 100);
    cyc(700, 100, 1, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 100, 0, 0, 0, 1);
    cyc(0, 100, 0, 0, 0, 1);
    chk("rst_in", in_border, 0); chk("rst_col", color, 0); chk("rst_busy", flash_busy, 0);
    px(0, 100);   chk("h0_in", in_border, 1); chk("h0_col", color, 63);
    px(7, 100);   chk("h7_in", in_border, 1);
    px(8, 100);   chk("h8_in", in_border, 0);
    px(632, 100); chk("h632_in", in_border, 1);
    px(639, 100); chk("h639_in", in_border, 1);
    px(640, 100); chk("h640_in", in_border, 0);
    px(300, 0);
`ifdef BORDER_TOP_BOTTOM_EN
    chk("top_in", in_border, 1); chk("top_col", color, 63);
    px(300, 472); chk("bot472_in", in_border, 1);
    px(300, 471); chk("bot471_in", in_border, 0);
`else
    chk("top_off_in", in_border, 0);
`endif
    cyc(700, 100, 0, 1, 0, 0);
    for (int k = 1; k <= 32; k++) begin
      px(3, 100);
      chk("lflash_col", color, (((k - 1) / 4) % 2 == 0) ? 3 : 63);
      if (k == 1) begin px(2, 2); chk("corner_col", color, 3); end
      px(636, 100);
      chk("right_steady", color, 63);
      chk("lflash_busy", flash_busy, 1);
      cyc(700, 100, 1, 0, 0, 0);
    end
    px(3, 100); chk("lflash_done_busy", flash_busy, 0); chk("lflash_done_col", color, 63);
    cyc(700, 100, 0, 1, 0, 0);
    for (int k = 0; k < 22; k++) frame();
    cyc(700, 100, 1, 1, 0, 0);
    px(3, 100); chk("retrig_on", color, 3);
    for (int k = 0; k < 27; k++) frame();
    cyc(700, 100, 0, 0, 0, 1);
    px(3, 100); chk("rst_mid_busy", flash_busy, 0); chk("rst_mid_col", color, 63);
    cyc(700, 100, 0, 1, 1, 0);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) cyc(700, 100, 0, 0, 1, 0);
      frame();
    end
    for (int i = 0; i < 4000; i++) begin
      int h, sel;
      sel = $urandom_range(0, 3);
      h = sel == 0 ? $urandom_range(0, 15) : sel == 1 ? $urandom_range(625, 645) : $urandom_range(0, 1023);
      cyc(h, $urandom_range(0, 511), $urandom_range(0, 7) == 0, $urandom_range(0, 150) == 0,
          $urandom_range(0, 150) == 0, $urandom_range(0, 800) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
